// File: rtl/reg_dst_pipe_if.sv
// rtl/reg_dst_pipe_if.sv - decode-side bundle for the destination-register pipeline
interface reg_dst_pipe_if #(
  parameter int AW    = 5,
  parameter int DEPTH = 3,
  parameter int SW    = $clog2(DEPTH + 1)
);
  // decode -> pipeline
  logic                  in_valid;
  logic [AW-1:0]         rt;
  logic [AW-1:0]         rd;
  logic [1:0]            dst_sel;
  logic                  reg_write;
  logic                  stall;
  logic                  flush;
  logic [AW-1:0]         rs_q;
  logic [AW-1:0]         rt_q;

  // pipeline -> register file / forwarding
  logic [DEPTH*AW-1:0]   stage_dst;
  logic [DEPTH-1:0]      stage_we;
  logic [AW-1:0]         a3;
  logic                  we;
  logic [SW-1:0]         fwd_rs;
  logic [SW-1:0]         fwd_rt;
  logic                  busy;

  // decode stage side
  modport master (
    output in_valid, rt, rd, dst_sel, reg_write, stall, flush, rs_q, rt_q,
    input  stage_dst, stage_we, a3, we, fwd_rs, fwd_rt, busy
  );

  // pipeline side
  modport slave (
    input  in_valid, rt, rd, dst_sel, reg_write, stall, flush, rs_q, rt_q,
    output stage_dst, stage_we, a3, we, fwd_rs, fwd_rt, busy
  );
endinterface

// File: rtl/reg_dst_pipe.sv
// rtl/reg_dst_pipe.sv - write-back destination select, DEPTH-stage carry and forwarding hits
module reg_dst_pipe #(
  parameter int AW       = 5,
  parameter int DEPTH    = 3,
  parameter int LINK_REG = 31,
  parameter int SW       = $clog2(DEPTH + 1)
) (
  input logic         clk,
  input logic         rst_n,
  reg_dst_pipe_if.slave bus
);

  localparam logic [AW-1:0] LINK = AW'(LINK_REG);

  logic [AW-1:0]    sel_dst;
  logic             new_we;

  logic [AW-1:0]    stage_dst_q [DEPTH];
  logic [AW-1:0]    stage_dst_d [DEPTH];
  logic [DEPTH-1:0] stage_we_q;
  logic [DEPTH-1:0] stage_we_d;

  logic [DEPTH-1:0] hit_rs;
  logic [DEPTH-1:0] hit_rt;
  logic [SW-1:0]    fwd_rs;
  logic [SW-1:0]    fwd_rt;

  // Destination mux and write qualification; register 0 is never written.
  always_comb begin
    sel_dst = '0;
    case (bus.dst_sel)
      2'b00:   sel_dst = bus.rt;
      2'b01:   sel_dst = bus.rd;
      2'b10:   sel_dst = LINK;
      default: sel_dst = '0;
    endcase
    new_we = bus.in_valid & bus.reg_write & (bus.dst_sel != 2'b11) & (sel_dst != '0);
  end

  // Next-state: stage 0 loads or bubbles, older stages always shift because
  // their instructions are already committed past decode.
  always_comb begin
    stage_we_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      stage_dst_d[i] = '0;
    end

    if (bus.flush) begin
      // flush kills the presented instruction; it wins over stall
      stage_dst_d[0] = '0;
      stage_we_d[0]  = 1'b0;
    end else if (bus.stall) begin
      stage_dst_d[0] = '0;
      stage_we_d[0]  = 1'b0;
    end else begin
      stage_dst_d[0] = sel_dst;
      stage_we_d[0]  = new_we;
    end

    for (int i = 1; i < DEPTH; i++) begin
      stage_dst_d[i] = stage_dst_q[i-1];
      stage_we_d[i]  = stage_we_q[i-1];
    end
  end

  // Stage registers; reset empties the whole pipeline immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_dst_q[i] <= '0;
      end
      stage_we_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_dst_q[i] <= stage_dst_d[i];
      end
      stage_we_q <= stage_we_d;
    end
  end

  // Per-stage hit against decode's sources; source register 0 never forwards.
  always_comb begin
    hit_rs = '0;
    hit_rt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_rs[i] = stage_we_q[i] & (stage_dst_q[i] == bus.rs_q) & (bus.rs_q != '0);
      hit_rt[i] = stage_we_q[i] & (stage_dst_q[i] == bus.rt_q) & (bus.rt_q != '0);
    end
  end

  // Priority encode: scan oldest to youngest so the youngest producer overrides.
  always_comb begin
    fwd_rs = '0;
    fwd_rt = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (hit_rs[i]) begin
        fwd_rs = SW'(i + 1);
      end
      if (hit_rt[i]) begin
        fwd_rt = SW'(i + 1);
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_pack
    assign bus.stage_dst[g*AW +: AW] = stage_dst_q[g];
  end

  assign bus.stage_we = stage_we_q;
  // With DEPTH = 1 the only stage is also write-back.
  assign bus.a3       = stage_dst_q[DEPTH-1];
  assign bus.we       = stage_we_q[DEPTH-1];
  assign bus.fwd_rs   = fwd_rs;
  assign bus.fwd_rt   = fwd_rt;
  assign bus.busy     = |stage_we_q;

endmodule

// File: doc/reg_dst_pipe.md
# reg_dst_pipe

Parametrised successor to the 2:1 rt/rd destination select. It picks the write-back register address from rt, rd or a fixed link register, or marks "no write". It carries the address and write-enable through DEPTH pipeline stages with stall-bubble and flush control. It sits between decode and the register file: the last stage drives the register-file write port (a3/we), and every in-flight stage is compared against decode's source registers to drive forwarding selects.

## Interface
Parameters:
- AW, 5, register-address width.
- DEPTH, 3, number of pipeline stages (stage 0 = EX … stage DEPTH-1 = WB); legal range 1–8.
- LINK_REG, 31, destination used when dst_sel = 2'b10.
- SW, $clog2(DEPTH+1), width of forwarding selects.

Ports:
- clk, input, 1, rising-edge clock; the only clock.
- rst_n, input, 1, reset: asynchronous, active-low.
- in_valid, input, 1, a decoded instruction is presented this cycle.
- rt, input, AW, instruction rt field.
- rd, input, AW, instruction rd field.
- dst_sel, input, 2, destination select: 00 = rt, 01 = rd, 10 = LINK_REG, 11 = none.
- reg_write, input, 1, instruction writes a register.
- stall, input, 1, decode stall: stage 0 takes a bubble, later stages advance.
- flush, input, 1, kill stage 0 and discard the presented instruction.
- rs_q, input, AW, decode source register 1.
- rt_q, input, AW, decode source register 2.
- stage_dst, output, DEPTH*AW, registered destination per stage; stage i occupies bits [i*AW +: AW].
- stage_we, output, DEPTH, registered write-enable per stage.
- a3, output, AW, register-file write address; equals stage DEPTH-1 dst.
- we, output, 1, register-file write enable; equals stage_we[DEPTH-1].
- fwd_rs, output, SW, youngest stage holding rs_q plus 1; 0 = no hit.
- fwd_rt, output, SW, same for rt_q.
- busy, output, 1, at least one stage_we bit is set.

## Operation
- Destination mux (combinational): sel_dst = rt / rd / LINK_REG / 0 per dst_sel.
- Enable: new_we = in_valid & reg_write & (dst_sel != 11) & (sel_dst != 0). Writes to register 0 are always suppressed, and their dst is stored as 0.
- Stage 0 load, by priority:
  - flush: dst = 0, we = 0.
  - else stall: dst = 0, we = 0 (bubble).
  - else: dst = sel_dst, we = new_we.
- Stages 1..DEPTH-1 shift from stage i-1 every cycle, unconditionally. Neither stall nor flush holds or clears them; the instructions they hold are architecturally committed past decode.
- Flush and stall asserted together: flush wins. The result is identical (bubble) but is counted as a flush for verification.
- Hit detection (combinational on current registers and queries): hit_x[i] = stage_we[i] & (stage_dst[i] == x_q) & (x_q != 0).
- fwd_x = (lowest i with hit_x[i]) + 1, else 0. The youngest producer wins when several stages match.
- busy = |stage_we.
- DEPTH = 1: stage 0 is also the WB stage, so a3/we come straight from the stage-0 registers.

## Timing
- Reset (rst_n low, asynchronous): all stage_dst = 0, all stage_we = 0, so a3 = 0, we = 0, fwd_rs = fwd_rt = 0, busy = 0. The reset takes effect immediately, without a clock.
- Reset released mid-stream: the pipeline restarts empty. Stage 0 captures the first instruction on the first rising edge with rst_n high.
- Latency: an instruction accepted at edge N appears on a3/we after edge N+DEPTH-1, i.e. DEPTH cycles of occupancy. With DEPTH = 3 it is in EX for cycle 1, MEM for cycle 2 and WB for cycle 3.
- Throughput: one instruction per cycle with no backpressure. A stall costs exactly one bubble per stalled cycle.
- fwd_rs, fwd_rt and busy are purely combinational from the registers and rs_q/rt_q. They are valid in the same cycle, with no added latency.
- Every register updates on the rising clk edge only.

## Test plan
- Reset: hold rst_n = 0 and drive random inputs. Required: a3 = 0, we = 0, busy = 0, fwd_rs = fwd_rt = 0. Release rst_n, send rd = 7 with dst_sel = 01 and reg_write = 1. Required: a3 = 7 and we = 1 exactly 3 cycles later (DEPTH = 3).
- Select modes: send rt = 5 (dst_sel = 00), rd = 9 (01), link (10) and none (11) on consecutive cycles. Required a3 sequence: 5, 9, 31, then we = 0. Also send rd = 0 with dst_sel = 01. Required: we = 0.
- Forwarding priority: send rd = 4 on two back-to-back cycles, then set rs_q = 4. Required: fwd_rs = 1 (stage 0). One cycle later, with stage 0 now a bubble: fwd_rs = 2. Set rs_q = 0 while stage 0 writes 0 suppressed. Required: fwd_rs = 0.
- Stall: send rd = 3, then assert stall for 2 cycles while presenting rd = 6. Required: stage 0 holds we = 0 for both cycles and rd = 3 still reaches WB on schedule. When stall drops, rd = 6 enters stage 0.
- Flush with stall: assert flush and stall together with rd = 8. Required: stage 0 we = 0, older stages keep advancing, and 8 never appears on a3.
- Async reset mid-stream: pulse rst_n low between edges while 3 writes are in flight. Required: we = 0 and busy = 0 immediately, with no in-flight write surfacing afterwards.
